// File: rtl/rd_route_pkg.sv
// Shared definitions for the read router: format codes, info field layout, lane mask.
// No logic; pure constants and a helper function.
// info layout is {src, chan[2:0], fmt[1:0]} with fmt in the LSBs.
package rd_route_pkg;

   localparam logic [1:0] FMT_PASS = 2'b00;
   localparam logic [1:0] FMT_565  = 2'b01;
   localparam logic [1:0] FMT_GREY = 2'b10;

   localparam int INFO_FMT_LSB  = 0;
   localparam int INFO_FMT_W    = 2;
   localparam int INFO_CHAN_LSB = 2;
   localparam int INFO_CHAN_W   = 3;
   localparam int INFO_SRC_LSB  = 5;

   // chan=0 enables every lane; chan=k enables lanes 0..k-1.
   function automatic logic lane_enabled(input logic [INFO_CHAN_W-1:0] chan, input int lane);
      return (chan == '0) || (lane < int'(chan));
   endfunction

endpackage

// File: rtl/rd_route_if.sv
// Bundle of the router's request, per-source address, per-source return and merged output buses.
// slave: the router's view (requests and returns in, addresses and merged data out).
// master: the surrounding system's view (mirror of slave).
interface rd_route_if #(
   parameter int NS = 2,
   parameter int DN = 8,
   parameter int DW = 8,
   parameter int AW = 13,
   parameter int SW = $clog2(NS)
);
   logic [SW+4:0]        info;
   logic [AW-1:0]        m_addr;
   logic                 m_addr_first, m_addr_last, m_addr_valid, m_addr_ready;
   logic [NS*AW-1:0]     s_addr;
   logic [NS-1:0]        s_addr_first, s_addr_last, s_addr_valid, s_addr_ready;
   logic [NS*DN*DW-1:0]  m_data;
   logic [NS-1:0]        m_data_first, m_data_last, m_data_valid, m_data_ready;
   logic [DN*DW-1:0]     s_data;
   logic                 s_data_first, s_data_last, s_data_valid, s_data_ready;

   modport slave (
      input  info, m_addr, m_addr_first, m_addr_last, m_addr_valid,
      output m_addr_ready,
      output s_addr, s_addr_first, s_addr_last, s_addr_valid,
      input  s_addr_ready,
      input  m_data, m_data_first, m_data_last, m_data_valid,
      output m_data_ready,
      output s_data, s_data_first, s_data_last, s_data_valid,
      input  s_data_ready
   );

   modport master (
      output info, m_addr, m_addr_first, m_addr_last, m_addr_valid,
      input  m_addr_ready,
      input  s_addr, s_addr_first, s_addr_last, s_addr_valid,
      output s_addr_ready,
      output m_data, m_data_first, m_data_last, m_data_valid,
      input  m_data_ready,
      input  s_data, s_data_first, s_data_last, s_data_valid,
      output s_data_ready
   );
endinterface

// File: rtl/rd_route_oq.sv
// Order queue: synchronous FIFO of burst descriptors; head is combinational from storage.
// Ports: push/din write, pop advances head, full/empty from a registered occupancy count.
// Latency: a push becomes visible at head the following cycle; push to full / pop from empty ignored.
module rd_route_oq #(
   parameter int W = 6,
   parameter int D = 4,
   parameter int CW = $clog2(D + 1),
   parameter int PW = $clog2(D)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   logic [W-1:0]  mem [D];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          do_push, do_pop;

   assign full    = (count == CW'(D));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because D is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/rd_route.sv
// Read router: steers request bursts to one of NS sources and merges returns back in issue order,
// applying format conversion and channel masking. Ports: clk, rst, bus (rd_route_if.slave).
// Latency 1 cycle on both paths (2-entry skid slices); non-head sources are stalled until their turn.
module rd_route
   import rd_route_pkg::*;
#(
   parameter int NS  = 2,
   parameter int DN  = 8,
   parameter int DW  = 8,
   parameter int AW  = 13,
   parameter int OQD = 4,
   parameter int SW  = $clog2(NS)
) (
   input  logic      clk,
   input  logic      rst,
   rd_route_if.slave bus
);
   localparam int LW = DN * DW;
   localparam int QW = SW + 5;
   localparam int AP = AW + 2;     // address slice payload {addr, first, last}
   localparam int DP = LW + 2;     // data slice payload {data, first, last}

   // Out-of-range source ids fold onto the last source.
   function automatic logic [SW-1:0] clip(input logic [SW-1:0] s);
      return (int'(s) >= NS) ? SW'(NS - 1) : s;
   endfunction

   // ---------------- request side ----------------
   logic [SW-1:0] burst_src, route_src;
   logic [NS-1:0] a_in_rdy;
   logic [AP-1:0] a_in_dat;
   logic          addr_rdy, a_fire;
   logic [QW-1:0] oq_head;
   logic          oq_full, oq_empty, oq_push, oq_pop;

   // First beats route on live info, later beats on the latched source.
   assign route_src = clip(bus.m_addr_first ? bus.info[INFO_SRC_LSB +: SW] : burst_src);
   // A first beat needs a queue slot; a pop in the same cycle does not free one early.
   assign addr_rdy  = !rst && a_in_rdy[route_src] && !(bus.m_addr_first && oq_full);
   assign a_fire    = bus.m_addr_valid && addr_rdy;
   assign oq_push   = a_fire && bus.m_addr_first;
   assign a_in_dat  = {bus.m_addr, bus.m_addr_first, bus.m_addr_last};
   assign bus.m_addr_ready = addr_rdy;

   always_ff @(posedge clk) begin
      if (rst)          burst_src <= '0;
      else if (oq_push) burst_src <= bus.info[INFO_SRC_LSB +: SW];
   end

   for (genvar i = 0; i < NS; i++) begin : g_src
      logic          in_vld, out_vld, skid_vld;
      logic [AP-1:0] out_dat, skid_dat;

      assign in_vld      = a_fire && (route_src == SW'(i));
      assign a_in_rdy[i] = !skid_vld;   // registered, so upstream never sees a downstream ready path

      always_ff @(posedge clk) begin
         if (rst) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_dat  <= '0;
            skid_dat <= '0;
         end else if (!out_vld || bus.s_addr_ready[i]) begin
            if (skid_vld) begin
               out_dat  <= skid_dat;
               out_vld  <= 1'b1;
               skid_vld <= 1'b0;
            end else begin
               out_dat  <= a_in_dat;
               out_vld  <= in_vld;
            end
         end else if (in_vld) begin
            skid_dat <= a_in_dat;
            skid_vld <= 1'b1;
         end
      end

      assign bus.s_addr[i*AW +: AW] = out_dat[AP-1:2];
      assign bus.s_addr_first[i]    = out_dat[1];
      assign bus.s_addr_last[i]     = out_dat[0];
      assign bus.s_addr_valid[i]    = out_vld;
   end

   rd_route_oq #(.W(QW), .D(OQD)) u_oq (
      .clk   (clk),
      .rst   (rst),
      .push  (oq_push),
      .pop   (oq_pop),
      .din   (bus.info),
      .head  (oq_head),
      .full  (oq_full),
      .empty (oq_empty)
   );

   // ---------------- return side ----------------
   logic [SW-1:0] hsrc;
   logic [2:0]    hchan;
   logic [1:0]    hfmt;
   logic [LW-1:0] sel_dat, conv, masked;
   logic          sel_vld, sel_first, sel_last, d_take, d_fire;
   logic          d_out_vld, d_skid_vld;
   logic [DP-1:0] d_out_dat, d_skid_dat, d_in_dat;

   assign hsrc      = clip(oq_head[INFO_SRC_LSB +: SW]);
   assign hchan     = oq_head[INFO_CHAN_LSB +: INFO_CHAN_W];
   assign hfmt      = oq_head[INFO_FMT_LSB +: INFO_FMT_W];
   assign sel_dat   = bus.m_data[int'(hsrc)*LW +: LW];
   assign sel_first = bus.m_data_first[hsrc];
   assign sel_last  = bus.m_data_last[hsrc];
   assign sel_vld   = bus.m_data_valid[hsrc];

   // Only the head source ever sees ready; everything else waits its turn.
   assign d_take           = !rst && !oq_empty && !d_skid_vld;
   assign d_fire           = d_take && sel_vld;
   assign oq_pop           = d_fire && sel_last;
   assign bus.m_data_ready = d_take ? (NS'(1) << hsrc) : '0;

   always_comb begin
      conv = '0;
      case (hfmt)
         FMT_565: begin
            conv[2*DW +: 8] = {sel_dat[15:11], 3'b000};
            conv[DW +: 8]   = {sel_dat[10:5], 2'b00};
            conv[7:0]       = {sel_dat[4:0], 3'b000};
         end
         FMT_GREY: begin
            for (int l = 0; l < 3; l++) conv[l*DW +: DW] = sel_dat[DW-1:0];
         end
         FMT_PASS: conv = sel_dat;
         default:  conv = sel_dat;
      endcase
      masked = conv;
      for (int l = 0; l < DN; l++) begin
         if (!lane_enabled(hchan, l)) masked[l*DW +: DW] = '0;
      end
   end

   assign d_in_dat = {masked, sel_first, sel_last};

   always_ff @(posedge clk) begin
      if (rst) begin
         d_out_vld  <= 1'b0;
         d_skid_vld <= 1'b0;
         d_out_dat  <= '0;
         d_skid_dat <= '0;
      end else if (!d_out_vld || bus.s_data_ready) begin
         if (d_skid_vld) begin
            d_out_dat  <= d_skid_dat;
            d_out_vld  <= 1'b1;
            d_skid_vld <= 1'b0;
         end else begin
            d_out_dat  <= d_in_dat;
            d_out_vld  <= d_fire;
         end
      end else if (d_fire) begin
         d_skid_dat <= d_in_dat;
         d_skid_vld <= 1'b1;
      end
   end

   assign bus.s_data       = d_out_dat[DP-1:2];
   assign bus.s_data_first = d_out_dat[1];
   assign bus.s_data_last  = d_out_dat[0];
   assign bus.s_data_valid = d_out_vld;
endmodule

// File: doc/rd_route.md
RD_ROUTE -- requirements
Module: rd_route

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NS, 2: number of read sources (2..8).
- DN, 8: byte lanes per beat.
- DW, 8: lane width.
- AW, 13: address width.
- OQD, 4: order-queue depth (power of 2).
- SW, $clog2(NS): source-select width (derived).
REQ-002 The block SHALL use one clock `clk`. Reset `rst` SHALL be synchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- info, in, SW+5: {src, chan[2:0], fmt[1:0]}; sampled only on an accepted first address beat.
- m_addr, in, AW: request address.
- m_addr_first, m_addr_last, m_addr_valid, in, 1 each: request burst delimiters and valid.
- m_addr_ready, out, 1: request ready.
- s_addr, out, NS*AW: per-source address.
- s_addr_first, s_addr_last, s_addr_valid, out, NS each: per-source burst delimiters and valid.
- s_addr_ready, in, NS: per-source ready.
- m_data, in, NS*DN*DW: per-source return data.
- m_data_first, m_data_last, m_data_valid, in, NS each: per-source return delimiters and valid.
- m_data_ready, out, NS: per-source return ready.
- s_data, out, DN*DW: merged output data.
- s_data_first, s_data_last, s_data_valid, out, 1 each: output delimiters and valid.
- s_data_ready, in, 1: output ready.

Function
REQ-004 On an accepted m_addr beat with m_addr_first=1, the block SHALL latch info into a burst register and push {src,chan,fmt} into the order queue in the same cycle.
REQ-005 All beats through the one with m_addr_last=1 SHALL route to the latched src, regardless of info changes mid-burst.
REQ-006 m_addr_ready SHALL be 0 on a first beat while the order queue is full, even if a pop occurs that cycle.
REQ-007 Each source address path SHALL be a 2-entry skid register: latency 1 cycle, full throughput, no combinational ready path to upstream. src >= NS SHALL route to source NS-1.
REQ-008 Return selection SHALL use the order-queue head only. When the queue is empty, every m_data_ready SHALL be 0 and no data SHALL be accepted.
REQ-009 m_data_ready[head.src] SHALL equal the output slice's ready; all other m_data_ready bits SHALL be 0.
REQ-010 Format conversion on the selected beat:
- fmt=00: pass the beat unchanged.
- fmt=01 (RGB565 in bits[15:0]): lane2={d[15:11],3'b0}, lane1={d[10:5],2'b0}, lane0={d[4:0],3'b0}, all other lanes 0.
- fmt=10: lane0 byte replicated to lanes 0..2, other lanes 0.
- fmt=11: treat as 00.
REQ-011 Channel mask applied after conversion: chan=0 enables all lanes; chan=k (1..7) enables lanes 0..k-1; disabled lanes SHALL output 0.
REQ-012 The output SHALL be a 2-entry skid slice carrying {data,first,last}, latency 1 cycle, full throughput.
REQ-013 The head SHALL pop when a beat with m_data_last=1 is accepted from the head source. The next burst's beats SHALL be accepted from the following cycle.
REQ-014 A burst returning from a non-head source SHALL stall with ready=0 until it becomes head; no reordering.
REQ-015 A push to an empty queue SHALL make the head visible one cycle later; same-cycle push and pop with count < OQD SHALL keep count unchanged.

Reset
REQ-016 On rst=1 the block SHALL clear the order queue, burst register and all slices. All outputs SHALL be 0: valids, readies, data, first/last.
REQ-017 After reset, m_addr_ready SHALL return to 1 on the first cycle after rst deasserts.
REQ-018 Reset mid-burst SHALL discard all in-flight beats. After reset, no stale beat SHALL appear on s_data.

Structure
REQ-019 A shared package rd_route_pkg SHALL hold the fmt encodings (FMT_PASS, FMT_565, FMT_GREY), the info field offsets, and the channel-mask function.
REQ-020 One sub-module, rd_route_oq, SHALL implement the order queue: synchronous FIFO with push/pop/full/empty/head and a count of OQD+1 states.

Verification
REQ-021 The bench SHALL cover these scenarios:
- V1: NS=2; 4-beat burst to src1, fmt=01, chan=0; m_data[15:0]=16'hF81F -> s_data lanes2..0 = F8,00,F8; first on beat 0, last on beat 3.
- V2: burst A (src0, 2 beats) then B (src1, 2 beats); src1 returns first -> src1 held (ready=0) until A's last is output; output order A0,A1,B0,B1.
- V3: OQD=4; 5 single-beat bursts with no returns -> m_addr_ready=0 on the 5th first beat; it rises the cycle after the first return's last beat is accepted.
- V4: chan=3, fmt=00, data 64'h8877665544332211 -> s_data=64'h0000000000332211.
- V5: s_data_ready toggles 1010 during an 8-beat burst -> no beat lost or duplicated; throughput 1/cycle when ready is held at 1.
- V6: rst asserted on beat 2 of a 4-beat burst -> all valids 0 the next cycle, queue empty, and a fresh burst completes correctly.
